// File: rtl/jtpopeye_rom_pkg.sv
// Shared encodings for the ROM arbiter: FSM states, slot owners, default SDRAM offsets.
// No logic: constants plus the word-address helper.
// No handshake of its own.
package jtpopeye_rom_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_OBJ = 1'b1;

    localparam logic [21:0] DEF_CPU_OFFSET = 22'h000000;
    localparam logic [21:0] DEF_OBJ_OFFSET = 22'h002000;

    // Region offset plus word address, wrapping at 2^22.
    function automatic logic [21:0] word_addr(input logic [21:0] offset, input logic [12:0] word);
        return offset + {9'd0, word};
    endfunction

endpackage

// File: rtl/jtpopeye_rom_arb_if.sv
// SDRAM read-port bundle between the ROM arbiter (master) and the SDRAM controller (slave).
// Latency set by the controller; ack and rdy are single-cycle pulses.
// sdram_req/sdram_addr are held stable until sdram_ack.
interface jtpopeye_rom_arb_if;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    modport master (output sdram_req, sdram_addr, input sdram_ack, data_rdy, data_read);
    modport slave  (input sdram_req, sdram_addr, output sdram_ack, data_rdy, data_read);
endinterface

// File: rtl/jtpopeye_rom_slot.sv
// One-entry tag/data cache with combinational hit compare.
// Hit is visible the cycle after a fill; invalidate takes priority over fill.
// No backpressure: fill is accepted whenever asserted.
module jtpopeye_rom_slot #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          inval,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data,
    output logic          hit,
    output logic [DW-1:0] data
);
    logic [AW-1:0] tag;
    logic          valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            tag   <= fill_tag;
            data  <= fill_data;
            valid <= 1'b1;
        end
    end

    assign hit = cs && valid && (tag == addr);

endmodule

// File: rtl/jtpopeye_rom_arb.sv
// Arbitrates CPU and object ROM misses onto one SDRAM read port, each backed by a one-word cache.
// Request issued 1 clk after a miss appears; *_ok rises the clk after data_rdy.
// sdram_req held until sdram_ack; new requests are blocked while downloading.
module jtpopeye_rom_arb
    import jtpopeye_rom_pkg::*;
#(
    parameter logic [21:0] CPU_OFFSET = DEF_CPU_OFFSET,
    parameter logic [21:0] OBJ_OFFSET = DEF_OBJ_OFFSET
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      downloading,
    input  logic                      cpu_cs,
    input  logic [14:0]               cpu_addr,
    output logic [7:0]                cpu_data,
    output logic                      cpu_ok,
    input  logic                      obj_cs,
    input  logic [12:0]               obj_addr,
    output logic [31:0]               obj_data,
    output logic                      obj_ok,
    jtpopeye_rom_arb_if.master        sdram
);
    logic [1:0]  state;
    logic        owner;
    logic        last_grant;
    logic [12:0] req_word;
    logic [31:0] cpu_word;
    logic        cpu_miss, obj_miss, pick_obj, done;

    assign cpu_miss = cpu_cs && !cpu_ok;
    assign obj_miss = obj_cs && !obj_ok;
    // Object fetch has priority, but the CPU gets the next slot after any object grant.
    assign pick_obj = obj_miss && !(last_grant == OWN_OBJ && cpu_miss);
    assign done     = (state == ST_WAIT_RDY && sdram.data_rdy) ||
                      (state == ST_WAIT_ACK && sdram.sdram_ack && sdram.data_rdy);

    jtpopeye_rom_slot #(.AW(13), .DW(32)) u_cpu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cpu_cs),
        .addr      (cpu_addr[14:2]),
        .inval     (downloading),
        .fill      (done && owner == OWN_CPU),
        .fill_tag  (req_word),
        .fill_data (sdram.data_read),
        .hit       (cpu_ok),
        .data      (cpu_word)
    );

    jtpopeye_rom_slot #(.AW(13), .DW(32)) u_obj_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (obj_cs),
        .addr      (obj_addr),
        .inval     (downloading),
        .fill      (done && owner == OWN_OBJ),
        .fill_tag  (req_word),
        .fill_data (sdram.data_read),
        .hit       (obj_ok),
        .data      (obj_data)
    );

    assign cpu_data = cpu_word[{cpu_addr[1:0], 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            owner            <= OWN_CPU;
            last_grant       <= OWN_CPU;
            req_word         <= '0;
            sdram.sdram_req  <= 1'b0;
            sdram.sdram_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!downloading && (cpu_miss || obj_miss)) begin
                        owner            <= pick_obj ? OWN_OBJ : OWN_CPU;
                        last_grant       <= pick_obj ? OWN_OBJ : OWN_CPU;
                        req_word         <= pick_obj ? obj_addr : cpu_addr[14:2];
                        sdram.sdram_addr <= pick_obj ? word_addr(OBJ_OFFSET, obj_addr)
                                                     : word_addr(CPU_OFFSET, cpu_addr[14:2]);
                        sdram.sdram_req  <= 1'b1;
                        state            <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram.sdram_ack) begin
                        sdram.sdram_req <= 1'b0;
                        state           <= sdram.data_rdy ? ST_IDLE : ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (sdram.data_rdy) state <= ST_IDLE;
                end
                default: begin
                    sdram.sdram_req <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// Directed bench for jtpopeye_rom_arb with a hand-driven SDRAM controller.
module tb_jtpopeye_rom_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        cpu_cs, obj_cs, cpu_ok, obj_ok;
    logic [14:0] cpu_addr;
    logic [12:0] obj_addr;
    logic [7:0]  cpu_data;
    logic [31:0] obj_data;
    int          total = 0;
    int          bad   = 0;

    jtpopeye_rom_arb_if sif();

    jtpopeye_rom_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .cpu_cs      (cpu_cs),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ok      (cpu_ok),
        .obj_cs      (obj_cs),
        .obj_addr    (obj_addr),
        .obj_data    (obj_data),
        .obj_ok      (obj_ok),
        .sdram       (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a request, checks its address, optionally checks it is held,
    // then pulses ack; with same=1, data_rdy arrives in the ack cycle.
    task automatic start_ack(input int hold, input logic [21:0] exp_addr, input string tag,
                             input bit same, input logic [31:0] d);
        int n = 0;
        while (!sif.sdram_req && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_req"}, {31'd0, sif.sdram_req}, 32'd1);
        check({tag, "_addr"}, {10'd0, sif.sdram_addr}, {10'd0, exp_addr});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {9'd0, sif.sdram_req, sif.sdram_addr}, {9'd0, 1'b1, exp_addr});
        end
        sif.sdram_ack = 1'b1;
        if (same) begin
            sif.data_read = d;
            sif.data_rdy  = 1'b1;
        end
        @(posedge clk); #1;
        sif.sdram_ack = 1'b0;
        sif.data_rdy  = 1'b0;
        check({tag, "_reqdrop"}, {31'd0, sif.sdram_req}, 32'd0);
    endtask

    task automatic give_rdy(input logic [31:0] d);
        sif.data_read = d;
        sif.data_rdy  = 1'b1;
        @(posedge clk); #1;
        sif.data_rdy  = 1'b0;
    endtask

    task automatic quiet(input int cycles, input string tag);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (sif.sdram_req) seen++;
        end
        check(tag, seen, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; downloading = 1'b0;
        cpu_cs = 1'b0; cpu_addr = '0; obj_cs = 1'b0; obj_addr = '0;
        sif.sdram_ack = 1'b0; sif.data_rdy = 1'b0; sif.data_read = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req",      {31'd0, sif.sdram_req}, 32'd0);
        check("rst_addr",     {10'd0, sif.sdram_addr}, 32'd0);
        check("rst_cpu_ok",   {31'd0, cpu_ok}, 32'd0);
        check("rst_obj_ok",   {31'd0, obj_ok}, 32'd0);
        check("rst_cpu_data", {24'd0, cpu_data}, 32'd0);
        check("rst_obj_data", obj_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: object miss, fill, then hits without SDRAM traffic
        obj_cs = 1'b1; obj_addr = 13'h0010;
        start_ack(2, 22'h002010, "t1", 1'b0, 32'd0);
        give_rdy(32'hCAFEF00D);
        check("t1_obj_ok",   {31'd0, obj_ok}, 32'd1);
        check("t1_obj_data", obj_data, 32'hCAFEF00D);
        quiet(3, "t1_noreq");

        // 2: CPU fill and byte select
        cpu_cs = 1'b1; cpu_addr = 15'h0123;
        start_ack(0, 22'h000048, "t2", 1'b0, 32'd0);
        give_rdy(32'h44332211);
        check("t2_cpu_ok",   {31'd0, cpu_ok}, 32'd1);
        check("t2_cpu_b3",   {24'd0, cpu_data}, 32'h44);
        cpu_addr = 15'h0120;
        #1;
        check("t2_cpu_b0",   {24'd0, cpu_data}, 32'h11);
        check("t2_cpu_ok0",  {31'd0, cpu_ok}, 32'd1);
        quiet(2, "t2_noreq");

        // 3: simultaneous misses alternate OBJ, CPU, OBJ
        cpu_addr = 15'h0200; obj_addr = 13'h0020;
        start_ack(0, 22'h002020, "t3a", 1'b0, 32'd0);
        give_rdy(32'hA0A0A0A0);
        check("t3a_obj_ok", {31'd0, obj_ok}, 32'd1);
        obj_addr = 13'h0021;
        start_ack(0, 22'h000080, "t3b", 1'b0, 32'd0);
        give_rdy(32'h55667788);
        check("t3b_cpu_ok",   {31'd0, cpu_ok}, 32'd1);
        check("t3b_cpu_data", {24'd0, cpu_data}, 32'h88);
        obj_addr = 13'h0022;
        start_ack(0, 22'h002022, "t3c", 1'b0, 32'd0);
        give_rdy(32'hB1B2B3B4);
        check("t3c_obj_ok",   {31'd0, obj_ok}, 32'd1);
        check("t3c_obj_data", obj_data, 32'hB1B2B3B4);

        // 4: address change while waiting for data
        obj_addr = 13'h0010;
        start_ack(0, 22'h002010, "t4a", 1'b0, 32'd0);
        obj_addr = 13'h0011;
        give_rdy(32'h01010101);
        check("t4_stale_ok", {31'd0, obj_ok}, 32'd0);
        start_ack(0, 22'h002011, "t4b", 1'b0, 32'd0);
        give_rdy(32'h02020202);
        check("t4_obj_ok",   {31'd0, obj_ok}, 32'd1);
        check("t4_obj_data", obj_data, 32'h02020202);

        // 5: download starts during WAIT_ACK
        obj_addr = 13'h0030;
        @(posedge clk); #1;
        check("t5_req_now", {31'd0, sif.sdram_req}, 32'd1);
        downloading = 1'b1;
        start_ack(0, 22'h002030, "t5", 1'b0, 32'd0);
        give_rdy(32'hDEADBEEF);
        check("t5_obj_ok", {31'd0, obj_ok}, 32'd0);
        check("t5_cpu_ok", {31'd0, cpu_ok}, 32'd0);
        quiet(4, "t5_noreq");
        downloading = 1'b0;
        start_ack(0, 22'h000080, "t5cpu", 1'b0, 32'd0);
        give_rdy(32'h99887766);
        check("t5_cpu_ok2",  {31'd0, cpu_ok}, 32'd1);
        check("t5_cpu_data", {24'd0, cpu_data}, 32'h66);

        // 6: ack and rdy in the same cycle, then reset while waiting for data
        start_ack(0, 22'h002030, "t6", 1'b1, 32'h12345678);
        check("t6_obj_ok",   {31'd0, obj_ok}, 32'd1);
        check("t6_obj_data", obj_data, 32'h12345678);
        obj_addr = 13'h0031;
        @(posedge clk); #1;
        check("t6_idle_req", {31'd0, sif.sdram_req}, 32'd1);
        start_ack(0, 22'h002031, "t6b", 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req",    {31'd0, sif.sdram_req}, 32'd0);
        check("t6_rst_obj_ok", {31'd0, obj_ok}, 32'd0);
        check("t6_rst_cpu_ok", {31'd0, cpu_ok}, 32'd0);
        check("t6_rst_data",   obj_data, 32'd0);
        cpu_cs = 1'b0; obj_cs = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        give_rdy(32'hFFFFFFFF);
        obj_cs = 1'b1;
        #1;
        check("t6_rdy_ignored", {31'd0, obj_ok}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
